data_mem_port: RTL and testbench
================================

DATA_MEM_PORT -- requirements
Module: data_mem_port

Interface
REQ-001 Parameter: IO_SEL, default 2'b11, value of addr[17:16] that marks a memory-mapped I/O access.
REQ-002 clk_in  input  1  system clock; every register samples on its rising edge.
REQ-003 rst_in  input  1  reset; asynchronous, active-high.
REQ-004 rdy_in  input  1  global enable; when low, all state holds.
REQ-005 cache_valid  input  1  request present; held high by the initiator until it sees cache_ready.
REQ-006 cache_wr  input  1  1 = store, 0 = load.
REQ-007 cache_size  input  3  [1:0] 0 = byte, 1 = half, 2 = word; [2] 1 = zero-extend (load only), 0 = sign-extend.
REQ-008 cache_addr  input  32  byte address.
REQ-009 cache_value  input  32  store data, little-endian.
REQ-010 cache_ready  output  1  one-cycle completion pulse.
REQ-011 cache_res  output  32  extended load result; valid while cache_ready is high; 0 for stores.
REQ-012 mem_din  input  8  RAM read byte; valid one cycle after mem_a is presented.
REQ-013 mem_dout  output  8  RAM write byte.
REQ-014 mem_a  output  32  RAM byte address.
REQ-015 mem_wr  output  1  1 = write mem_dout to mem_a this cycle.
REQ-016 io_buffer_full  input  1  I/O output buffer is full; I/O stores must wait.

Function
REQ-017 Byte count n SHALL be 1, 2 or 4 from cache_size[1:0]; size code 3 SHALL be treated as 4.
REQ-018 States SHALL be IDLE, READ, WRITE and DONE; all outputs SHALL be registered.
REQ-019 IDLE SHALL accept a request at an edge where cache_valid=1, except that a store with addr[17:16]==IO_SEL SHALL wait in IDLE while io_buffer_full=1.
REQ-020 On acceptance the block SHALL latch addr, size, wr and value, then enter WRITE if wr=1 or READ if wr=0. Cycle 1 is the first cycle after the accepting edge.
REQ-021 WRITE: in cycle i+1 (i = 0..n-1) the block SHALL drive mem_a=addr+i, mem_dout=value[8i+7:8i] and mem_wr=1.
REQ-022 WRITE completion: in cycle n+1, cache_ready=1, mem_wr=0 and cache_res=0.
REQ-023 READ: in cycle i+1 the block SHALL drive mem_a=addr+i with mem_wr=0, and SHALL capture mem_din in cycle i+2 as byte i.
REQ-024 READ completion: in cycle n+2, cache_ready=1 and cache_res holds the assembled bytes.
REQ-025 Extension: bits above 8n SHALL be copied from bit 8n-1 if cache_size[2]=0, and set to 0 if cache_size[2]=1; a word load SHALL ignore cache_size[2].
REQ-026 Address arithmetic SHALL be 32-bit modulo (addr+i wraps past 0xFFFFFFFF); no alignment is required.
REQ-027 DONE SHALL last exactly one cycle, SHALL ignore cache_valid (it still carries the old request), and SHALL return to IDLE.
REQ-028 Back-to-back requests: a request held high after DONE SHALL be accepted at the first IDLE edge, giving one idle cycle between requests.
REQ-029 Outside WRITE, mem_wr SHALL be 0; in IDLE and DONE, mem_a SHALL be 0.
REQ-030 When rdy_in=0, state, counters and captured bytes SHALL hold, mem_wr SHALL be 0, and the cycle SHALL not count toward latency.
REQ-031 A READ cycle with rdy_in=0 SHALL re-present the same mem_a in the next enabled cycle before capturing.
REQ-032 A stalled I/O store SHALL be accepted on the first edge after io_buffer_full drops; the latency rules above then apply.
REQ-033 io_buffer_full SHALL be sampled only in IDLE, so a store already in WRITE completes regardless.

Reset
REQ-034 On rst_in=1, immediately and independently of clk_in, the block SHALL go to IDLE.
REQ-035 Reset values: cache_ready=0, cache_res=0, mem_a=0, mem_dout=0, mem_wr=0, counters=0.
REQ-036 Reset mid-operation SHALL abandon the transfer with no further mem_wr and no cache_ready pulse.

Verification
REQ-037 Word load: addr 0x100, RAM bytes 78 56 34 12 -> mem_a 0x100..0x103 in cycles 1-4; cache_ready in cycle 6; cache_res=0x12345678.
REQ-038 Signed and unsigned byte load: RAM[0x200]=0x80 with size 3'b000, then size 3'b100 -> 0xFFFFFF80, then 0x00000080.
REQ-039 Half store: value 0xAABBCCDD, addr 0x10 -> writes 0xDD@0x10 (cycle 1) and 0xCC@0x11 (cycle 2); ready in cycle 3; no other mem_wr.
REQ-040 I/O stall: store byte to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr during the stall; the write occurs in the cycle after acceptance once full=0.
REQ-041 Back-to-back with freeze: two loads held valid, with rdy_in=0 for 2 cycles mid-read -> correct results, latency extended by 2 cycles, and one idle cycle between them.
REQ-042 Asynchronous reset during the third byte of a word store -> outputs reach reset values before the next edge, and no cache_ready is asserted.

Source files
------------

// File: rtl/data_mem_port.sv
// Byte-serial bridge between a cache-side load/store request and an 8-bit RAM.
// Loads walk mem_a once per enabled cycle and collect mem_din one cycle later;
// stores emit one byte write per cycle. Results are sign- or zero-extended.
module data_mem_port #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        cache_valid,
  input  logic        cache_wr,
  input  logic [2:0]  cache_size,
  input  logic [31:0] cache_addr,
  input  logic [31:0] cache_value,
  output logic        cache_ready,
  output logic [31:0] cache_res,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  step_reg, step_next;     // index of the current enabled cycle of the transfer
  logic [31:0] addr_reg, addr_next;
  logic [2:0]  size_reg, size_next;
  logic [31:0] value_reg, value_next;
  logic [31:0] data_reg, data_next;     // load bytes collected so far
  logic [7:0]  skid_reg, skid_next;     // byte that arrived during the first frozen cycle
  logic        skid_valid_reg, skid_valid_next;

  logic        cache_ready_next;
  logic [31:0] cache_res_next;
  logic [31:0] mem_a_next;
  logic [7:0]  mem_dout_next;
  logic        mem_wr_next;

  logic [2:0]  nbytes;
  logic        io_block;
  logic [7:0]  rd_byte;
  logic [1:0]  rd_idx;
  logic [31:0] assembled;

  // Size code 3 is treated like a word.
  assign nbytes   = (size_reg[1:0] == 2'd0) ? 3'd1 :
                    (size_reg[1:0] == 2'd1) ? 3'd2 : 3'd4;
  assign io_block = cache_wr && (cache_addr[17:16] == IO_SEL) && io_buffer_full;
  // A byte that showed up while frozen is no longer on mem_din, so use the saved copy.
  assign rd_byte  = skid_valid_reg ? skid_reg : mem_din;
  assign rd_idx   = 2'(step_reg - 3'd2);

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] size);
    logic [31:0] res;
    case (size[1:0])
      2'd0:    res = size[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    res = size[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_next       = state_reg;
    step_next        = step_reg;
    addr_next        = addr_reg;
    size_next        = size_reg;
    value_next       = value_reg;
    data_next        = data_reg;
    skid_next        = skid_reg;
    skid_valid_next  = skid_valid_reg;
    cache_ready_next = 1'b0;
    cache_res_next   = cache_res;
    mem_a_next       = mem_a;
    mem_dout_next    = mem_dout;
    mem_wr_next      = 1'b0;
    assembled        = data_reg;
    assembled[{rd_idx, 3'b000} +: 8] = rd_byte;

    if (!rdy_in) begin
      // Frozen: everything holds, but a load byte due now would be lost, so keep it.
      cache_ready_next = cache_ready;
      if (state_reg == READ && step_reg >= 3'd2 && !skid_valid_reg) begin
        skid_next       = mem_din;
        skid_valid_next = 1'b1;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          mem_a_next     = 32'd0;
          cache_res_next = 32'd0;
          if (cache_valid && !io_block) begin
            addr_next       = cache_addr;
            size_next       = cache_size;
            value_next      = cache_value;
            data_next       = 32'd0;
            step_next       = 3'd1;
            skid_valid_next = 1'b0;
            mem_a_next      = cache_addr;
            if (cache_wr) begin
              state_next    = WRITE;
              mem_dout_next = cache_value[7:0];
              mem_wr_next   = 1'b1;
            end else begin
              state_next    = READ;
            end
          end
        end
        WRITE: begin
          if (step_reg < nbytes) begin
            mem_a_next    = addr_reg + 32'(step_reg);
            mem_dout_next = value_reg[{step_reg[1:0], 3'b000} +: 8];
            mem_wr_next   = 1'b1;
            step_next     = step_reg + 3'd1;
          end else begin
            mem_a_next       = 32'd0;
            cache_ready_next = 1'b1;
            cache_res_next   = 32'd0;
            step_next        = 3'd0;
            state_next       = DONE;
          end
        end
        READ: begin
          skid_valid_next = 1'b0;
          if (step_reg >= 3'd2) data_next = assembled;
          if (step_reg < nbytes) begin
            mem_a_next = addr_reg + 32'(step_reg);
            step_next  = step_reg + 3'd1;
          end else if (step_reg == nbytes) begin
            mem_a_next = 32'd0;
            step_next  = step_reg + 3'd1;
          end else begin
            mem_a_next       = 32'd0;
            cache_ready_next = 1'b1;
            cache_res_next   = extend(assembled, size_reg);
            step_next        = 3'd0;
            state_next       = DONE;
          end
        end
        DONE: begin
          mem_a_next = 32'd0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      step_reg       <= 3'd0;
      addr_reg       <= 32'd0;
      size_reg       <= 3'd0;
      value_reg      <= 32'd0;
      data_reg       <= 32'd0;
      skid_reg       <= 8'd0;
      skid_valid_reg <= 1'b0;
      cache_ready    <= 1'b0;
      cache_res      <= 32'd0;
      mem_a          <= 32'd0;
      mem_dout       <= 8'd0;
      mem_wr         <= 1'b0;
    end else begin
      step_reg       <= step_next;
      addr_reg       <= addr_next;
      size_reg       <= size_next;
      value_reg      <= value_next;
      data_reg       <= data_next;
      skid_reg       <= skid_next;
      skid_valid_reg <= skid_valid_next;
      cache_ready    <= cache_ready_next;
      cache_res      <= cache_res_next;
      mem_a          <= mem_a_next;
      mem_dout       <= mem_dout_next;
      mem_wr         <= mem_wr_next;
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port with a one-cycle-latency byte RAM model.
module tb_data_mem_port;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        cache_valid = 1'b0;
  logic        cache_wr = 1'b0;
  logic [2:0]  cache_size = 3'd0;
  logic [31:0] cache_addr = 32'd0;
  logic [31:0] cache_value = 32'd0;
  logic        cache_ready;
  logic [31:0] cache_res;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t         wr_q[$];
  logic [31:0] amon [0:31];

  logic [7:0]  ram [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a = 12'd0;
  logic [7:0]  pre_d = 8'd0;

  data_mem_port #(.IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cache_valid(cache_valid), .cache_wr(cache_wr), .cache_size(cache_size),
    .cache_addr(cache_addr), .cache_value(cache_value),
    .cache_ready(cache_ready), .cache_res(cache_res),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM: synchronous write, read data valid the cycle after the address.
  always @(posedge clk_in) begin
    if (pre_we)      ram[pre_a] <= pre_d;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk_in); #1;
    pre_we = 1'b0;
  endtask

  task automatic set_req(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] value);
    cache_wr = wr; cache_size = size; cache_addr = addr; cache_value = value;
    cache_valid = 1'b1;
  endtask

  // Called just before the accepting edge (after skip extra edges). Cycle k is the
  // k-th cycle after acceptance; rdy_in is low in cycles stall_at and stall_at+1.
  task automatic run_txn(input string tag, input int skip, input int stall_at,
                         input int exp_lat, input logic [31:0] exp_res);
    int lat;
    wr_t w;
    lat = 0;
    wr_q.delete();
    for (int i = 0; i < 32; i++) amon[i] = 32'hDEADBEEF;
    for (int s = 0; s < skip; s++) begin
      @(posedge clk_in); #1;
      check({tag, "-gap-ready"}, 32'(cache_ready), 32'd0);
    end
    @(posedge clk_in);
    for (int k = 1; k <= 30; k++) begin
      #1;
      rdy_in = !(stall_at > 0 && (k == stall_at || k == stall_at + 1));
      @(negedge clk_in);
      amon[k] = mem_a;
      if (mem_wr) begin
        w.k = k; w.a = mem_a; w.d = mem_dout;
        wr_q.push_back(w);
      end
      if (cache_ready) begin
        lat = k;
        break;
      end
      @(posedge clk_in);
    end
    rdy_in = 1'b1;
    check({tag, "-latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "-res"}, cache_res, exp_res);
    $display("txn %s: latency=%0d res=%08h writes=%0d", tag, lat, cache_res, wr_q.size());
  endtask

  task automatic finish_txn();
    cache_valid = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    int bad;
    // Preload RAM while the DUT is held in reset.
    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    poke(12'h200, 8'h80);
    poke(12'h300, 8'h34); poke(12'h301, 8'h92);
    poke(12'hFFE, 8'h11); poke(12'hFFF, 8'h22); poke(12'h000, 8'h33); poke(12'h001, 8'h44);
    poke(12'h042, 8'h5A);
    @(negedge clk_in);
    check("reset-ready", 32'(cache_ready), 32'd0);
    check("reset-res", cache_res, 32'd0);
    check("reset-mem_a", mem_a, 32'd0);
    check("reset-mem_wr", 32'(mem_wr), 32'd0);
    check("reset-mem_dout", 32'(mem_dout), 32'd0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Word load.
    set_req(1'b0, 3'b010, 32'h100, 32'd0);
    run_txn("wload", 0, 0, 6, 32'h12345678);
    check("wload-a1", amon[1], 32'h100);
    check("wload-a2", amon[2], 32'h101);
    check("wload-a4", amon[4], 32'h103);
    check("wload-nowr", 32'(wr_q.size()), 32'd0);
    finish_txn();

    // Signed then unsigned byte load.
    set_req(1'b0, 3'b000, 32'h200, 32'd0);
    run_txn("bload-s", 0, 0, 3, 32'hFFFFFF80);
    finish_txn();
    set_req(1'b0, 3'b100, 32'h200, 32'd0);
    run_txn("bload-u", 0, 0, 3, 32'h00000080);
    finish_txn();

    // Unaligned word load wrapping past the top of the address space.
    set_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0);
    run_txn("wrap", 0, 0, 6, 32'h44332211);
    check("wrap-a2", amon[2], 32'hFFFFFFFF);
    check("wrap-a3", amon[3], 32'h0);
    finish_txn();

    // Half store.
    set_req(1'b1, 3'b001, 32'h10, 32'hAABBCCDD);
    run_txn("hstore", 0, 0, 3, 32'h0);
    check("hstore-nwr", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() == 2) begin
      check("hstore-w0-cyc", 32'(wr_q[0].k), 32'd1);
      check("hstore-w0-a", wr_q[0].a, 32'h10);
      check("hstore-w0-d", 32'(wr_q[0].d), 32'hDD);
      check("hstore-w1-cyc", 32'(wr_q[1].k), 32'd2);
      check("hstore-w1-a", wr_q[1].a, 32'h11);
      check("hstore-w1-d", 32'(wr_q[1].d), 32'hCC);
    end
    finish_txn();

    // Back-to-back loads, first one frozen for two cycles mid-read.
    set_req(1'b0, 3'b001, 32'h300, 32'd0);
    run_txn("b2b-1", 0, 2, 6, 32'hFFFF9234);
    set_req(1'b0, 3'b111, 32'h100, 32'd0);
    run_txn("b2b-2", 1, 0, 6, 32'h12345678);
    finish_txn();

    // I/O store stalled by a full buffer.
    io_buffer_full = 1'b1;
    set_req(1'b1, 3'b000, 32'h00030000, 32'h000000A5);
    bad = 0;
    repeat (5) begin
      @(negedge clk_in);
      if (mem_wr || cache_ready) bad++;
    end
    check("io-stall-quiet", 32'(bad), 32'd0);
    io_buffer_full = 1'b0;
    run_txn("io-store", 0, 0, 2, 32'h0);
    check("io-nwr", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) begin
      check("io-w-cyc", 32'(wr_q[0].k), 32'd1);
      check("io-w-a", wr_q[0].a, 32'h00030000);
      check("io-w-d", 32'(wr_q[0].d), 32'hA5);
    end
    finish_txn();

    // Asynchronous reset during the third byte of a word store.
    set_req(1'b1, 3'b010, 32'h40, 32'h11223344);
    @(posedge clk_in);
    repeat (3) @(negedge clk_in);
    check("rst-pre-a", mem_a, 32'h42);
    check("rst-pre-wr", 32'(mem_wr), 32'd1);
    cache_valid = 1'b0;
    rst_in = 1'b1;
    #1;
    check("rst-async-wr", 32'(mem_wr), 32'd0);
    check("rst-async-a", mem_a, 32'd0);
    check("rst-async-dout", 32'(mem_dout), 32'd0);
    check("rst-async-ready", 32'(cache_ready), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk_in);
      if (mem_wr || cache_ready) bad++;
    end
    check("rst-after-quiet", 32'(bad), 32'd0);
    check("rst-ram-41", 32'(ram[12'h041]), 32'h33);
    check("rst-ram-42", 32'(ram[12'h042]), 32'h5A);
    $display("txn rst-store: abandoned after two bytes");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
